// File: rtl/slow_rom_prefetch.sv
// Instruction fetch front end: reads a slow ROM sequentially into a show-ahead queue of tagged words.
// First word ROM_LATENCY cycles after reset/jump; a full queue stalls the ROM until the core pops.
module slow_rom_prefetch #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 2,
    parameter int DEPTH       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDR_WIDTH-1:0]    rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    input  logic                     fetch_ready,
    input  logic                     jump,
    input  logic [ADDR_WIDTH-1:0]    jump_addr,
    output logic [DATA_WIDTH-1:0]    ir,
    output logic                     ir_valid,
    output logic [ADDR_WIDTH-1:0]    pc,
    output logic [$clog2(DEPTH):0]   fill_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam logic [CW-1:0] WCNT_LAST = CW'(ROM_LATENCY - 1);
    localparam logic [PW:0]   FULL      = (PW+1)'(DEPTH);

    typedef enum logic {ST_WAIT, ST_IDLE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [ADDR_WIDTH-1:0] tag_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] tag_d  [DEPTH];
    logic                  do_pop;
    logic                  do_push;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rom_addr_d = rom_addr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        tag_d      = tag_q;
        do_pop     = fetch_ready && (cnt_q != '0);
        do_push    = 1'b0;

        if (jump) begin
            // Flushing the queue and restarting the counter drops any in-flight access.
            do_pop     = 1'b0;
            cnt_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            rom_addr_d = jump_addr;
            wcnt_d     = '0;
            state_d    = ST_WAIT;
        end else begin
            if (state_q == ST_WAIT) begin
                if (wcnt_q == WCNT_LAST) begin
                    do_push = (cnt_q != FULL) || do_pop;
                    if (do_push) begin
                        data_d[wr_ptr_q] = rom_data;
                        tag_d[wr_ptr_q]  = rom_addr_q;
                        wr_ptr_d         = wr_ptr_q + 1'b1;
                        rom_addr_d       = rom_addr_q + 1'b1;
                        wcnt_d           = '0;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end else if (do_pop) begin
                state_d = ST_WAIT;
                wcnt_d  = '0;
            end

            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            if (do_push && (cnt_d == FULL)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_WAIT;
            wcnt_q     <= '0;
            rom_addr_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            data_q     <= '{default: '0};
            tag_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rom_addr_q <= rom_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            tag_q      <= tag_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign fill_level = cnt_q;
    assign ir_valid   = (cnt_q != '0);
    assign ir         = ir_valid ? data_q[rd_ptr_q] : '0;
    assign pc         = ir_valid ? tag_q[rd_ptr_q] : rom_addr_q;

endmodule

// File: tb/tb_slow_rom_prefetch.sv
// Bench for slow_rom_prefetch: two configurations (latency 2/depth 2 and latency 1/depth 4) run side by side.
module tb_slow_rom_prefetch;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_word(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int L  = (g == 0) ? 2 : 1;
        localparam int D  = (g == 0) ? 2 : 4;
        localparam int FW = $clog2(D) + 1;

        logic          reset, fetch_ready, jump, ir_valid;
        logic [7:0]    jump_addr, rom_addr, rom_data, ir, pc;
        logic [FW-1:0] fill_level;
        bit            done = 1'b0;

        slow_rom_prefetch #(
            .ADDR_WIDTH(8), .DATA_WIDTH(8), .ROM_LATENCY(L), .DEPTH(D)
        ) dut (
            .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
            .fetch_ready(fetch_ready), .jump(jump), .jump_addr(jump_addr),
            .ir(ir), .ir_valid(ir_valid), .pc(pc), .fill_level(fill_level)
        );

        // ROM: garbage until L-1 cycles after the address last changed.
        logic [7:0] last_addr = 8'h00;
        int         age = 0;
        always @(negedge clk) begin
            if (rom_addr !== last_addr) begin
                age       = 0;
                last_addr = rom_addr;
            end else if (age < 1000) begin
                age = age + 1;
            end
            rom_data = (age >= L - 1) ? rom_word(rom_addr) : 8'($urandom);
        end

        // Reference: after a restart at address A the core must see A, A+1, ... in order.
        exp_t       exp_q[$];
        exp_t       e;
        int         since = 0;
        bit         armed = 1'b0;
        int         pops = 0;
        logic [7:0] restart_addr = 8'h00;

        always @(negedge clk) begin
            if (armed) begin
                chk("valid_vs_fill", 32'(ir_valid), 32'(fill_level != '0));
                chk("fill_max", 32'(int'(fill_level) <= D), 1);
                if (!ir_valid) begin
                    chk("ir_when_empty", 32'(ir), 0);
                    chk("pc_when_empty", 32'(pc), 32'(rom_addr));
                end
                if (since < L) chk("latency_low", 32'(ir_valid), 0);
                if (since == L) chk("latency_high", 32'(ir_valid), 1);
                if (since == 0) begin
                    chk("restart_fill", 32'(fill_level), 0);
                    chk("restart_addr", 32'(rom_addr), 32'(restart_addr));
                end
            end
            if (reset || jump) begin
                armed        = 1'b1;
                since        = 0;
                restart_addr = reset ? 8'h00 : jump_addr;
                exp_q.delete();
                for (int i = 0; i < 256; i++) begin
                    e.a = restart_addr + 8'(i);
                    e.d = rom_word(e.a);
                    exp_q.push_back(e);
                end
            end else begin
                if (since < 1000) since++;
                if (ir_valid && fetch_ready) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_underflow", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_pc", 32'(pc), 32'(e.a));
                        chk("pop_ir", 32'(ir), 32'(e.d));
                    end
                end
            end
        end

        initial begin
            int p0;
            reset = 1'b1; fetch_ready = 1'b0; jump = 1'b0; jump_addr = 8'h00;
            tick(3);
            reset = 1'b0;

            // Fill with no consumer, then the ROM must park.
            tick(D * L + 3);
            chk("fill_full", 32'(fill_level), D);
            chk("idle_addr", 32'(rom_addr), D);
            chk("first_ir", 32'(ir), 8'hA5);
            chk("first_pc", 32'(pc), 0);
            tick(5);
            chk("idle_hold", 32'(rom_addr), D);
            chk("idle_fill", 32'(fill_level), D);

            // Continuous consumption across the address wrap.
            jump = 1'b1; jump_addr = 8'hFE; fetch_ready = 1'b1;
            tick(1);
            jump = 1'b0;
            p0 = pops;
            tick(30);
            chk("throughput", 32'(pops - p0), 29 / L);

            // Jump again one cycle into an access.
            jump = 1'b1; jump_addr = 8'h10;
            tick(1);
            jump = 1'b0;
            tick(1);
            jump = 1'b1; jump_addr = 8'h40;
            tick(1);
            jump = 1'b0;
            tick(L);
            chk("jump_pc", 32'(pc), 8'h40);
            chk("jump_ir", 32'(ir), 8'hE5);
            tick(10);

            // Jump together with fetch_ready on a full queue.
            fetch_ready = 1'b0; jump = 1'b1; jump_addr = 8'h80;
            tick(1);
            jump = 1'b0;
            tick(D * L + 2);
            chk("prefull", 32'(fill_level), D);
            jump = 1'b1; jump_addr = 8'h33; fetch_ready = 1'b1;
            p0 = pops;
            tick(1);
            chk("jump_no_pop", 32'(pops - p0), 0);
            jump = 1'b0;
            tick(L);
            chk("flush_pc", 32'(pc), 8'h33);
            tick(7);

            // Reset mid-access with jump held; reset must win.
            reset = 1'b1; jump = 1'b1; jump_addr = 8'h77;
            tick(3);
            reset = 1'b0; jump = 1'b0;
            chk("reset_addr", 32'(rom_addr), 0);
            chk("reset_valid", 32'(ir_valid), 0);
            tick(L);
            chk("reset_pc", 32'(pc), 0);
            chk("reset_ir", 32'(ir), 8'hA5);

            // Fill, then alternate consumption.
            fetch_ready = 1'b0;
            tick(D * L + 2);
            for (int i = 0; i < 24; i++) begin
                fetch_ready = i[0];
                tick(1);
            end

            // Randomised traffic.
            for (int i = 0; i < 600; i++) begin
                reset       = ($urandom_range(0, 59) == 0);
                jump        = ($urandom_range(0, 11) == 0);
                jump_addr   = 8'($urandom);
                fetch_ready = ($urandom_range(0, 2) != 0);
                tick(1);
            end
            reset = 1'b0; jump = 1'b0; fetch_ready = 1'b0;
            tick(5);
            done = 1'b1;
        end
    end

    initial begin
        int cyc = 0;
        while (!(g_cfg[0].done && g_cfg[1].done) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (!(g_cfg[0].done && g_cfg[1].done)) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: stimulus still running after %0d cycles, expected completion", cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
